// File: rtl/mskrnd_pkg.sv
// Shared width helpers for the HPC1 G(4) randomness feeder: per-share randomness
// counts, word layout (refresh part low, multiplication part high) and counter sizing.
package mskrnd_pkg;

  localparam int REF_LO = 0;

  function automatic int ref_n_rnd(input int d);
    return d * (d - 1) / 2;
  endfunction

  function automatic int dom_rnd(input int d);
    return d * (d - 1) / 2;
  endfunction

  function automatic int ref_w(input int d);
    return 2 * ref_n_rnd(d);
  endfunction

  function automatic int mul_w(input int d);
    return 2 * dom_rnd(d);
  endfunction

  function automatic int rnd_w(input int d);
    return ref_w(d) + mul_w(d);
  endfunction

  function automatic int mul_lo(input int d);
    return REF_LO + ref_w(d);
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/mskrnd_fifo.sv
// DEPTH-entry randomness store with in-order head read; an entry is overwritten
// with zero as it is consumed so no spent randomness lingers in the array.
module mskrnd_fifo
  import mskrnd_pkg::*;
#(
  parameter int W     = 4,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_wdata,
  output logic [W-1:0] o_rdata,
  output logic         o_empty,
  output logic         o_full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_cnt;

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_empty = (r_cnt == '0);
  assign o_full  = (r_cnt == FULL_CNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      // Push is never issued when full, so it cannot land on the slot being zeroed.
      if (i_pop) begin
        r_mem[r_rd_ptr] <= '0;
        r_rd_ptr        <= r_rd_ptr + 1'b1;
      end
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_wdata;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      unique case ({i_push, i_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/mskg4mul_hpc1_rnd_feed.sv
// Randomness feeder for one HPC1 G(4) masked multiplier: refresh bits in the launch
// cycle, DOM bits 1+REF_RNDLAT cycles later. Define MSKRND_BYPASS_EN to feed straight through when empty.
module mskg4mul_hpc1_rnd_feed
  import mskrnd_pkg::*;
#(
  parameter int D          = 2,
  parameter int REF_RNDLAT = 1,
  parameter int DEPTH      = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [rnd_w(D)-1:0] in_rnd,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                start,
  output logic                rnd_avail,
  output logic [ref_w(D)-1:0] rnd_ref,
  output logic [mul_w(D)-1:0] rnd_mul,
  output logic                err
);

  localparam int RW   = rnd_w(D);
  localparam int RFW  = ref_w(D);
  localparam int MW   = mul_w(D);
  localparam int MLO  = mul_lo(D);
  localparam int NSTG = 1 + REF_RNDLAT;

  logic [RW-1:0]   w_head;
  logic            w_empty;
  logic            w_full;
  logic            w_push;
  logic            w_pop;
  logic            w_byp;
  logic [RFW-1:0]  w_ref;
  logic [MW-1:0]   w_dl_data;
  logic            w_dl_vld;

  logic [MW-1:0]   r_dl_data [NSTG];
  logic [NSTG-1:0] r_dl_vld;
  logic            r_err;

`ifdef MSKRND_BYPASS_EN
  assign w_byp = start & in_valid & w_empty;
`else
  assign w_byp = 1'b0;
`endif

  assign w_pop     = start & ~w_empty;
  assign w_push    = in_valid & ~w_full & ~w_byp;
  assign in_ready  = ~w_full;
  assign rnd_avail = ~w_empty;

  mskrnd_fifo #(
    .W     (RW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (in_rnd),
    .o_rdata (w_head),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  // Source of this launch's randomness: buffered head, bypassed input, or nothing.
  always_comb begin
    w_ref     = '0;
    w_dl_data = '0;
    w_dl_vld  = 1'b0;
    if (w_pop) begin
      w_ref     = w_head[REF_LO +: RFW];
      w_dl_data = w_head[MLO +: MW];
      w_dl_vld  = 1'b1;
    end else if (w_byp) begin
      w_ref     = in_rnd[REF_LO +: RFW];
      w_dl_data = in_rnd[MLO +: MW];
      w_dl_vld  = 1'b1;
    end
  end

  assign rnd_ref = w_ref;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NSTG; i++) begin
        r_dl_data[i] <= '0;
      end
      r_dl_vld <= '0;
      r_err    <= 1'b0;
    end else begin
      r_dl_data[0] <= w_dl_data;
      r_dl_vld[0]  <= w_dl_vld;
      for (int i = 1; i < NSTG; i++) begin
        r_dl_data[i] <= r_dl_data[i-1];
        r_dl_vld[i]  <= r_dl_vld[i-1];
      end
      if (start & w_empty & ~w_byp) begin
        r_err <= 1'b1;
      end
    end
  end

  assign rnd_mul = r_dl_vld[NSTG-1] ? r_dl_data[NSTG-1] : '0;
  assign err     = r_err;

endmodule
